pc_unit: RTL and testbench

- Parametrised program-counter unit for the fetch stage; successor to the single-register PC.
- Holds the PC and selects the next PC from sequential, branch, call, return, exception and exception-return sources, with fixed priority.
- Contains a circular return-address stack (RAS) for call/return and an exception PC (EPC) register.
- Feeds the instruction-memory address; control inputs come from the decode/execute/hazard logic.

---
 rtl/pc_unit.sv | 134 +++++++++++++
 tb/tb_pc_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- fetch-stage program-counter unit.
//
// Holds the PC and picks the next PC from (highest priority first):
// exception, exception return, branch, return (RAS pop), call (RAS push),
// and sequential advance. A circular return-address stack serves call/return,
// and an EPC register captures the PC at which an exception was taken.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   pc_write       advance enable (0 = stall; exceptions still act)
//   exc_valid      take exception
//   eret_valid     return from exception
//   branch_valid   taken branch / jump redirect to branch_target
//   branch_target  redirect address
//   call_valid     jump to call_target and push the return address
//   call_target    call destination
//   ret_valid      return: pop the RAS
//   pc_out         current PC (registered)
//   pc_plus        pc_out + INSTR_BYTES (combinational, wraps)
//   epc_out        saved exception PC (registered)
//   ras_count      number of valid RAS entries
//   ras_underflow  one-cycle pulse after a return taken with an empty RAS
// -----------------------------------------------------------------------------
module pc_unit #(
   parameter int                 ADDR_W      = 32,
   parameter logic [ADDR_W-1:0]  RESET_VEC   = '0,
   parameter logic [ADDR_W-1:0]  EXC_VEC     = ADDR_W'(32'h0000_0008),
   parameter int                 INSTR_BYTES = 4,
   parameter int                 RAS_DEPTH   = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             pc_write,
   input  logic                             exc_valid,
   input  logic                             eret_valid,
   input  logic                             branch_valid,
   input  logic [ADDR_W-1:0]                branch_target,
   input  logic                             call_valid,
   input  logic [ADDR_W-1:0]                call_target,
   input  logic                             ret_valid,
   output logic [ADDR_W-1:0]                pc_out,
   output logic [ADDR_W-1:0]                pc_plus,
   output logic [ADDR_W-1:0]                epc_out,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
   output logic                             ras_underflow
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH+1);

   // Clears the low log2(INSTR_BYTES) bits of redirect targets.
   localparam logic [ADDR_W-1:0] ALIGN_MASK =
      ~(ADDR_W'(INSTR_BYTES) - ADDR_W'(1));

   logic [ADDR_W-1:0] pc_q,  pc_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic [PTR_W-1:0]  top_q, top_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              uf_q,  uf_d;
   logic              push;
   logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

   // Wraps modulo 2^ADDR_W; carry is intentionally dropped.
   assign pc_plus = pc_q + ADDR_W'(INSTR_BYTES);

   always_comb begin
      pc_d  = pc_q;
      epc_d = epc_q;
      top_d = top_q;
      cnt_d = cnt_q;
      uf_d  = 1'b0;
      push  = 1'b0;
      if (exc_valid) begin
         // Exceptions bypass the stall and leave the RAS untouched.
         pc_d  = EXC_VEC & ALIGN_MASK;
         epc_d = pc_q;
      end else if (pc_write) begin
         if (eret_valid) begin
            pc_d = epc_q;
         end else if (branch_valid) begin
            pc_d = branch_target & ALIGN_MASK;
         end else if (ret_valid) begin
            if (cnt_q != '0) begin
               pc_d  = ras_q[top_q];
               top_d = top_q - PTR_W'(1);
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               pc_d = pc_plus;
               uf_d = 1'b1;
            end
         end else if (call_valid) begin
            pc_d  = call_target & ALIGN_MASK;
            top_d = top_q + PTR_W'(1);
            push  = 1'b1;
            // When full, the push overwrites the oldest entry; count saturates.
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            pc_d = pc_plus;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_VEC;
         epc_q <= '0;
         top_q <= '0;
         cnt_q <= '0;
         uf_q  <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         pc_q  <= pc_d;
         epc_q <= epc_d;
         top_q <= top_d;
         cnt_q <= cnt_d;
         uf_q  <= uf_d;
         if (push) begin
            ras_q[top_d] <= pc_plus;
         end
      end
   end

   assign pc_out        = pc_q;
   assign epc_out       = epc_q;
   assign ras_count     = cnt_q;
   assign ras_underflow = uf_q;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit -- directed self-checking bench for pc_unit (default parameters).
// -----------------------------------------------------------------------------
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_write;
   logic        exc_valid;
   logic        eret_valid;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic        call_valid;
   logic [31:0] call_target;
   logic        ret_valid;
   logic [31:0] pc_out;
   logic [31:0] pc_plus;
   logic [31:0] epc_out;
   logic [2:0]  ras_count;
   logic        ras_underflow;

   int n_chk  = 0;
   int n_pass = 0;

   pc_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_write      (pc_write),
      .exc_valid     (exc_valid),
      .eret_valid    (eret_valid),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .call_valid    (call_valid),
      .call_target   (call_target),
      .ret_valid     (ret_valid),
      .pc_out        (pc_out),
      .pc_plus       (pc_plus),
      .epc_out       (epc_out),
      .ras_count     (ras_count),
      .ras_underflow (ras_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      exc_valid    = 1'b0;
      eret_valid   = 1'b0;
      branch_valid = 1'b0;
      call_valid   = 1'b0;
      ret_valid    = 1'b0;
   endtask

   task automatic branch_to(input logic [31:0] tgt);
      branch_valid  = 1'b1;
      branch_target = tgt;
      tick();
      branch_valid  = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b0;
      pc_write      = 1'b1;
      branch_target = '0;
      call_target   = '0;
      idle();
      #12;
      check("rst_pc",    pc_out, 32'h0);
      check("rst_epc",   epc_out, 32'h0);
      check("rst_cnt",   32'(ras_count), 32'h0);
      check("rst_uf",    32'(ras_underflow), 32'h0);
      check("rst_plus",  pc_plus, 32'h4);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Sequential advance
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("seq_pc", pc_out, 32'(4 * i));
      end
      check("seq_cnt", 32'(ras_count), 32'h0);
      check("seq_epc", epc_out, 32'h0);

      // Stall then aligned branch
      pc_write = 1'b0;
      tick();
      check("stall1", pc_out, 32'd16);
      tick();
      check("stall2", pc_out, 32'd16);
      pc_write = 1'b1;
      branch_to(32'h102);
      check("br_align", pc_out, 32'h100);

      // Call, run, return
      branch_to(32'h20);
      call_valid  = 1'b1;
      call_target = 32'h400;
      tick();
      call_valid  = 1'b0;
      check("call_pc",  pc_out, 32'h400);
      check("call_cnt", 32'(ras_count), 32'h1);
      tick();
      check("run1", pc_out, 32'h404);
      tick();
      check("run2", pc_out, 32'h408);
      ret_valid = 1'b1;
      tick();
      ret_valid = 1'b0;
      check("ret_pc",  pc_out, 32'h24);
      check("ret_cnt", 32'(ras_count), 32'h0);
      check("ret_uf",  32'(ras_underflow), 32'h0);

      // Five calls into a 4-deep RAS
      branch_to(32'h0);
      call_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         call_target = 32'((i + 1) * 32'h100);
         tick();
         check("calls_pc",  pc_out, 32'((i + 1) * 32'h100));
         check("calls_cnt", 32'(ras_count), (i < 3) ? 32'(i + 1) : 32'd4);
      end
      call_valid = 1'b0;
      ret_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("pop_pc",  pc_out, 32'h404 - 32'(i * 32'h100));
         check("pop_cnt", 32'(ras_count), 32'(3 - i));
         check("pop_uf",  32'(ras_underflow), 32'h0);
      end
      tick();
      ret_valid = 1'b0;
      check("uflow_pc",  pc_out, 32'h108);
      check("uflow_uf",  32'(ras_underflow), 32'h1);
      check("uflow_cnt", 32'(ras_count), 32'h0);
      tick();
      check("uflow_clr", 32'(ras_underflow), 32'h0);
      check("uflow_nxt", pc_out, 32'h10C);

      // One live RAS entry, then exception under stall with competing controls
      call_valid  = 1'b1;
      call_target = 32'h4C;
      tick();
      call_valid  = 1'b0;
      tick();
      check("pre_exc_pc", pc_out, 32'h50);
      pc_write      = 1'b0;
      exc_valid     = 1'b1;
      branch_valid  = 1'b1;
      branch_target = 32'h900;
      call_valid    = 1'b1;
      call_target   = 32'hA00;
      tick();
      idle();
      check("exc_pc",  pc_out, 32'h8);
      check("exc_epc", epc_out, 32'h50);
      check("exc_cnt", 32'(ras_count), 32'h1);
      pc_write = 1'b1;
      tick();
      check("exc_run", pc_out, 32'hC);
      eret_valid = 1'b1;
      tick();
      eret_valid = 1'b0;
      check("eret_pc", pc_out, 32'h50);
      ret_valid = 1'b1;
      tick();
      ret_valid = 1'b0;
      check("ras_kept", pc_out, 32'h110);
      check("ras_kept_cnt", 32'(ras_count), 32'h0);

      // Wraparound
      branch_to(32'hFFFF_FFFC);
      check("wrap_pre",  pc_out, 32'hFFFF_FFFC);
      check("wrap_plus", pc_plus, 32'h0);
      tick();
      check("wrap_pc", pc_out, 32'h0);

      // Asynchronous reset in the middle of a call
      call_valid  = 1'b1;
      call_target = 32'h400;
      tick();
      check("pre_rst_cnt", 32'(ras_count), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_pc",  pc_out, 32'h0);
      check("arst_cnt", 32'(ras_count), 32'h0);
      check("arst_epc", epc_out, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
